clock_divider_n: RTL

- Programmable integer clock divider (divide-by-N) for the clk_in domain. It generalises the fixed divide-by-2 stage.
- Produces two registered outputs:
  - clk_out: a near-50% divided clock.
  - tick: a one-cycle enable pulse on each clk_out rising edge.
- Sits directly upstream of the prescaled logic. Downstream logic consumes tick as a clock-enable rather than using clk_out as a clock.
- The divisor can be changed at runtime. A change takes effect only on a period boundary, so it never produces a runt or glitch period.

---
 rtl/clock_divider_n.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clock_divider_n.sv
// ---------------------------------------------------------------------------
// clock_divider_n
//
// Programmable integer divide-by-N for the clk_in domain. It produces a
// registered, near-50% divided clock and a one-cycle tick for each rising
// edge of that clock. Downstream logic should use tick as a clock enable
// rather than clocking from clk_out.
//
// The divisor can be changed at runtime. A requested value is parked in a
// pending register and moved into force only at a period boundary (the
// counter wrap), or immediately when the divider is idle. Because of this,
// a change never produces a runt or glitched period.
//
// Ports
//   clk_in      in   1      system clock
//   rst         in   1      synchronous, active-high reset
//   en          in   1      run enable; 0 = idle (phase and outputs cleared)
//   div_val     in   CNT_W  requested divisor N (0 is treated as 1)
//   div_load    in   1      strobe: capture div_val into the pending register
//   div_ack     out  1      pulse: the pending divisor has just become active
//   div_active  out  CNT_W  divisor currently in force
//   clk_out     out  1      divided clock, high for ceil(N/2) of N cycles
//   tick        out  1      pulse coincident with each clk_out rising edge
// ---------------------------------------------------------------------------
module clock_divider_n #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic [CNT_W-1:0] div_active,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] active_q,   active_d;
    logic [CNT_W-1:0] pend_q,     pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q,  clk_out_d;
    logic             tick_q,     tick_d;
    logic             ack_q,      ack_d;

    logic [CNT_W:0]   half;
    logic             wrap;
    logic             apply;

    // High-phase length ceil(N/2). One extra bit keeps N = 2^CNT_W-1
    // from overflowing when the +1 is added.
    assign half = ({1'b0, active_q} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    // active_q is never 0, so N-1 cannot underflow.
    assign wrap = (cnt_q == (active_q - ONE_C));

    // While running, only swap divisors on the last cycle of a period; while
    // idle there is no period to protect, so swap at once.
    assign apply = pend_vld_q && (!en || wrap);

    always_comb begin
        cnt_d      = cnt_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        ack_d      = apply;

        if (en) begin
            clk_out_d = ({1'b0, cnt_q} < half);
            tick_d    = (cnt_q == '0);
            cnt_d     = wrap ? '0 : (cnt_q + ONE_C);
        end else begin
            cnt_d = '0;
        end

        if (apply) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
        end

        // A load in the same cycle as an apply becomes the next pending
        // value; the old pending value has already been consumed above.
        if (div_load) begin
            pend_d     = (div_val == '0) ? ONE_C : div_val;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q      <= '0;
            active_q   <= DIV_RST_C;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    // Pending value is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk_in) begin
        pend_q <= pend_d;
    end

    assign div_ack    = ack_q;
    assign div_active = active_q;
    assign clk_out    = clk_out_q;
    assign tick       = tick_q;

endmodule
